// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the async FIFO pointer engines.
// Functions work on a 32-bit word; callers zero-extend in and truncate out.
package gray_pkg;

  localparam int max_w = 32;
  localparam int default_addr_bits = 4;

  typedef logic [max_w-1:0] word_t;

  function automatic word_t bin2gray(input word_t v);
    return v ^ (v >> 1);
  endfunction

  // Upper zero bits contribute nothing to the prefix XOR, so zero-extension is safe.
  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b[max_w-1] = g[max_w-1];
    for (int i = max_w - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// Multi-flop synchroniser for a Gray-coded bus crossing into this clock domain.
// All stages reset synchronously to zero.
module gray_sync_chain #(
  parameter int width  = 5,
  parameter int stages = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  (* async_reg = "true", preserve = "true" *) logic [width-1:0] stage_q [stages];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < stages; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < stages; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[stages-1];

endmodule

// File: rtl/gray_fifo_ptr.sv
// One-side pointer engine of a dual-clock FIFO: local binary/Gray pointer, synchronised remote
// pointer, registered full/empty flag. Fill level is built only with GRAY_FIFO_PTR_LEVEL_EN.
module gray_fifo_ptr
  import gray_pkg::*;
#(
  parameter int addr_bits   = default_addr_bits,
  parameter bit is_write    = 1'b1,
  parameter int sync_stages = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  output logic                 ack,
  output logic [addr_bits-1:0] ptr_addr,
  output logic [addr_bits:0]   ptr_gray,
  input  logic [addr_bits:0]   remote_gray_in,
  output logic                 flag,
  output logic [addr_bits:0]   level
);

  localparam int ptr_w = addr_bits + 1;
  typedef logic [addr_bits:0] ptr_t;

  // Full when the remote pointer is exactly one lap behind: top two Gray bits inverted.
  localparam ptr_t full_mask = ptr_t'(3) << (addr_bits - 1);

  if (sync_stages < 2 || sync_stages > 4) begin : g_bad_stages
    $error("gray_fifo_ptr: sync_stages must be in 2..4");
  end

  ptr_t ptr_bin;
  ptr_t ptr_bin_next;
  ptr_t gray_next;
  ptr_t rg_s;
  logic flag_next;

  gray_sync_chain #(
    .width  (ptr_w),
    .stages (sync_stages)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (remote_gray_in),
    .q     (rg_s)
  );

  assign ack          = req & ~flag & ~reset;
  assign ptr_bin_next = ptr_bin + ptr_t'(ack);
  assign gray_next    = ptr_t'(bin2gray(word_t'(ptr_bin_next)));
  assign ptr_addr     = ptr_bin[addr_bits-1:0];

  always_comb begin
    flag_next = 1'b0;
    if (is_write) flag_next = (gray_next == (rg_s ^ full_mask));
    else          flag_next = (gray_next == rg_s);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_bin  <= '0;
      ptr_gray <= '0;
      flag     <= ~is_write;
    end else begin
      ptr_bin  <= ptr_bin_next;
      ptr_gray <= gray_next;
      flag     <= flag_next;
    end
  end

`ifdef GRAY_FIFO_PTR_LEVEL_EN
  ptr_t rb_s;
  ptr_t level_next;

  assign rb_s       = ptr_t'(gray2bin(word_t'(rg_s)));
  assign level_next = is_write ? (ptr_bin_next - rb_s) : (rb_s - ptr_bin_next);

  always_ff @(posedge clk) begin
    if (reset) level <= '0;
    else       level <= level_next;
  end
`else
  assign level = '0;
`endif

endmodule

// File: tb/tb_gray_fifo_ptr.sv
// Directed bench: one write-side and one read-side pointer engine (addr_bits=2, 2 sync stages).
module tb_gray_fifo_ptr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic       w_reset = 1'b1, w_req = 1'b0, w_ack, w_flag;
  logic [1:0] w_addr;
  logic [2:0] w_gray, w_remote = 3'd0, w_level;
  logic       r_reset = 1'b1, r_req = 1'b0, r_ack, r_flag;
  logic [1:0] r_addr;
  logic [2:0] r_gray, r_remote = 3'd0, r_level;

  gray_fifo_ptr #(.addr_bits(2), .is_write(1'b1), .sync_stages(2)) dut_w (
    .clk(clk), .reset(w_reset), .req(w_req), .ack(w_ack), .ptr_addr(w_addr),
    .ptr_gray(w_gray), .remote_gray_in(w_remote), .flag(w_flag), .level(w_level)
  );

  gray_fifo_ptr #(.addr_bits(2), .is_write(1'b0), .sync_stages(2)) dut_r (
    .clk(clk), .reset(r_reset), .req(r_req), .ack(r_ack), .ptr_addr(r_addr),
    .ptr_gray(r_gray), .remote_gray_in(r_remote), .flag(r_flag), .level(r_level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lvl(input int v);
`ifdef GRAY_FIFO_PTR_LEVEL_EN
    return 32'(v);
`else
    return 32'(v * 0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] gray_tab [8];
  int exp_bin;
  logic [2:0] prev_gray;

  initial begin
    gray_tab = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

    // 1: reset held 3 cycles with req high
    w_reset = 1'b1; w_req = 1'b1; w_remote = 3'd0;
    for (int i = 0; i < 3; i++) begin
      #1 check("rst_ack", w_ack, 0);
      tick();
    end
    check("rst_gray", w_gray, 0);
    check("rst_flag", w_flag, 0);
    check("rst_level", w_level, lvl(0));

    // 2: fill from empty with remote at 0
    w_reset = 1'b0;
    begin
      logic [2:0] exp_g [4];
      exp_g = '{3'd1, 3'd3, 3'd2, 3'd6};
      for (int i = 0; i < 4; i++) begin
        #1 check("fill_ack", w_ack, 1);
        tick();
        check("fill_gray", w_gray, 32'(exp_g[i]));
      end
    end
    check("fill_flag", w_flag, 1);
    check("fill_level", w_level, lvl(4));
    check("fill_addr", w_addr, 0);
    #1 check("full_ack", w_ack, 0);

    // 3: remote advances to bin 2; flag must linger, then drop
    w_req = 1'b0; w_remote = 3'd3;
    tick(); tick();
    check("linger_flag", w_flag, 1);
    tick();
    check("drain_flag", w_flag, 0);
    check("drain_level", w_level, lvl(2));
    w_req = 1'b1;
    #1 check("refill_ack1", w_ack, 1);
    tick();
    check("refill_gray1", w_gray, 7);
    check("refill_flag1", w_flag, 0);
    #1 check("refill_ack2", w_ack, 1);
    tick();
    check("refill_gray2", w_gray, 5);
    check("refill_flag2", w_flag, 1);
    check("refill_level", w_level, lvl(4));
    #1 check("refull_ack", w_ack, 0);

    // 4: wrap with the remote pointer chasing the local one
    w_reset = 1'b1; w_req = 1'b0; w_remote = 3'd0;
    tick();
    w_reset = 1'b0; w_req = 1'b1;
    exp_bin = 0;
    for (int i = 0; i < 20; i++) begin
      w_remote = gray_tab[exp_bin];
      prev_gray = w_gray;
      #1 check("wrap_ack", w_ack, 1);
      tick();
      exp_bin = (exp_bin + 1) % 8;
      check("wrap_gray", w_gray, 32'(gray_tab[exp_bin]));
      check("wrap_onebit", $countones(w_gray ^ prev_gray), 1);
      check("wrap_addr", w_addr, 32'(exp_bin % 4));
      check("wrap_flag", w_flag, 0);
    end

    // 5: read side
    r_reset = 1'b1; r_req = 1'b1; r_remote = 3'd0;
    #1 check("r_rst_ack", r_ack, 0);
    tick();
    check("r_rst_flag", r_flag, 1);
    check("r_rst_gray", r_gray, 0);
    r_reset = 1'b0;
    #1 check("r_empty_ack", r_ack, 0);
    r_req = 1'b0; r_remote = 3'd1;
    tick(); tick();
    check("r_linger_flag", r_flag, 1);
    tick();
    check("r_avail_flag", r_flag, 0);
    check("r_avail_level", r_level, lvl(1));
    r_req = 1'b1;
    #1 check("r_pop_ack", r_ack, 1);
    tick();
    check("r_pop_flag", r_flag, 1);
    check("r_pop_level", r_level, lvl(0));
    check("r_pop_gray", r_gray, 1);
    check("r_pop_addr", r_addr, 1);
    #1 check("r_pop2_ack", r_ack, 0);

    // 6: reset mid-fill with req held
    w_reset = 1'b1; w_req = 1'b0; w_remote = 3'd0;
    tick();
    w_reset = 1'b0; w_req = 1'b1;
    tick(); tick(); tick();
    check("mid_level", w_level, lvl(3));
    check("mid_gray", w_gray, 2);
    w_reset = 1'b1;
    #1 check("mid_rst_ack", w_ack, 0);
    tick();
    check("mid_rst_gray", w_gray, 0);
    check("mid_rst_level", w_level, lvl(0));
    check("mid_rst_flag", w_flag, 0);
    r_reset = 1'b1;
    tick();
    check("r_mid_rst_flag", r_flag, 1);
    check("r_mid_rst_gray", r_gray, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
